// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Splits a 32-bit MEM-stage load/store into two 16-bit SRAM
//               phases (LOW half, then HIGH half), each lasting WAIT_CYCLES
//               clocks, and freezes the pipeline while the access runs.
// Ports       : clk, rst (async, active-high)
//               rd_en, wr_en, address[31:0], write_data[31:0]  - CPU request
//               read_data[31:0], ready, freeze                  - CPU response
//               sram_addr[17:0], sram_dq_out[15:0], sram_dq_oe,
//               sram_dq_in[15:0], sram_we_n                     - SRAM side
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
  parameter int WAIT_CYCLES = 2   // cycles per 16-bit phase, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  C_LAST      = 4'(WAIT_CYCLES - 1);
  // The SRAM window starts at byte 1024, i.e. word 256. Because 1024 is a
  // multiple of 4, bits [18:2] of (address - 1024) equal address[18:2] - 256
  // modulo 2^17, so only those address bits need to be kept.
  localparam logic [16:0] C_WORD_BASE = 17'd256;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_is_wr;
  logic [16:0] r_word;
  logic [31:0] r_data;
  logic [16:0] w_word_off;
  logic        w_req;
  logic        w_last;
  logic        w_unused;

  assign w_req      = rd_en | wr_en;
  assign w_last     = (r_cnt == C_LAST);
  assign w_word_off = r_word - C_WORD_BASE;
  assign w_unused   = ^{address[31:19], address[1:0]};

  // State, phase counter and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_word  <= 17'd0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req) begin
        r_is_wr <= wr_en;
        r_word  <= address[18:2];
        r_data  <= write_data;
      end
    end
  end

  // Read capture on the final cycle of each phase, when the SRAM data has
  // had the full wait time to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (!r_is_wr && w_last) begin
      if (r_state == S_LOW) begin
        read_data[15:0] <= sram_dq_in;
      end else if (r_state == S_HIGH) begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

  // Next state and SRAM-side outputs
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt + 4'd1;
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (r_state)
      S_IDLE: begin
        ready      = ~w_req;
        w_cnt_next = 4'd0;
        if (w_req) begin
          w_next = S_LOW;
        end
      end
      S_LOW: begin
        sram_addr = {w_word_off, 1'b0};
        if (r_is_wr) begin
          sram_dq_out = r_data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_last) begin
          w_next     = S_HIGH;
          w_cnt_next = 4'd0;
        end
      end
      S_HIGH: begin
        sram_addr = {w_word_off, 1'b1};
        if (r_is_wr) begin
          sram_dq_out = r_data[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_last) begin
          w_next     = S_DONE;
          w_cnt_next = 4'd0;
        end
      end
      S_DONE: begin
        ready      = 1'b1;
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  assign freeze = w_req & ~ready;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Directed, table-driven bench for sram_controller with a small
//               half-word SRAM model, plus hand-written multi-cycle sequences
//               (back-to-back, reset mid-access, WAIT_CYCLES = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  // Second instance with WAIT_CYCLES = 1
  logic        rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, freeze1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;
  logic        dq_oe1, we_n1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1),
    .address(addr1), .write_data(wdata1), .read_data(rdata1),
    .ready(ready1), .freeze(freeze1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_oe(dq_oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1)
  );

  // SRAM model: 256 half-words, indexed by the low address bits.
  logic [15:0] mem [0:255];
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[2] <= 16'hBEEF;
      mem[3] <= 16'hDEAD;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = mem[sram_addr[7:0]];
  assign dq_in1     = sram_addr1[0] ? 16'hA5A5 : 16'h5A5A;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;   // read_data expected in DONE
  } vec_t;

  vec_t vecs [7];

  // One complete access with WAIT_CYCLES = 2: IDLE(0) LOW(1,2) HIGH(3,4) DONE(5)
  task automatic run_vec(input vec_t v);
    logic [31:0] a;
    logic [17:0] lo;
    logic        we_exp;
    logic [17:0] addr_exp;
    a  = v.addr - 32'd1024;
    lo = {a[18:2], 1'b0};
    @(posedge clk); #1;
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      we_exp   = !(v.wr && c >= 1 && c <= 4);
      addr_exp = (c == 1 || c == 2) ? lo : (c == 3 || c == 4) ? (lo | 18'd1) : 18'd0;
      check("ready", 32'(ready), 32'(c == 5));
      check("freeze", 32'(freeze), 32'(c != 5));
      check("we_n", 32'(sram_we_n), 32'(we_exp));
      check("dq_oe", 32'(sram_dq_oe), 32'(!we_exp));
      check("sram_addr", 32'(sram_addr), 32'(addr_exp));
      if (c == 1) begin
        check("dq_out_lo", 32'(sram_dq_out), v.wr ? 32'(v.wdata[15:0]) : 32'd0);
        // Latched values must not follow the bus after IDLE.
        address = ~v.addr; write_data = ~v.wdata;
      end
      if (c == 3) check("dq_out_hi", 32'(sram_dq_out), v.wr ? 32'(v.wdata[31:16]) : 32'd0);
      if (c == 5) begin
        check("read_data", read_data, v.exp_rd);
        rd_en = 1'b0; wr_en = 1'b0;
      end
    end
    if (v.wr) begin
      @(negedge clk);
      check("mem_lo", 32'(mem[lo[7:0]]), 32'(v.wdata[15:0]));
      check("mem_hi", 32'(mem[lo[7:0] + 8'd1]), 32'(v.wdata[31:16]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b1, 32'd1060, 32'hA5A55A5A, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd0,    32'h00000000, 32'h12345678};

    rst = 1'b1; mem_init = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back write then read with the request held throughout:
    // access 1 in cycles 0..5, access 2 in cycles 6..11.
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h11223344;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      check("b2b_freeze", 32'(freeze), 32'(c != 5 && c != 11));
      check("b2b_ready", 32'(ready), 32'(c == 5 || c == 11));
      if (c == 5) begin wr_en = 1'b0; rd_en = 1'b1; end
      if (c == 7) begin
        check("b2b_rd_we_n", 32'(sram_we_n), 32'd1);
        check("b2b_rd_addr", 32'(sram_addr), 32'd8);
      end
      if (c == 11) begin
        check("b2b_read_data", read_data, 32'h11223344);
        rd_en = 1'b0;
      end
    end

    // Reset pulsed in cycle 3 of a read; the held read restarts afterwards.
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1028;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstmid_read_data", read_data, 32'd0);
    check("rstmid_we_n", 32'(sram_we_n), 32'd1);
    check("rstmid_sram_addr", 32'(sram_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rstmid_ready", 32'(ready), 32'(c == 8));
      if (c == 8) begin
        check("rstmid_read_data_final", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
      end
    end

    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_freeze", 32'(freeze), 32'd0);

    // WAIT_CYCLES = 1: IDLE(0) LOW(1) HIGH(2) DONE(3)
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = 32'd1032;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      check("w1_ready", 32'(ready1), 32'(c == 3));
      if (c == 1) check("w1_addr_lo", 32'(sram_addr1), 32'd4);
      if (c == 2) check("w1_addr_hi", 32'(sram_addr1), 32'd5);
      if (c == 3) begin
        check("w1_read_data", rdata1, 32'hA5A55A5A);
        rd1 = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: clock cycles per 16-bit SRAM phase; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port rd_en, input, 1: MEM-stage load request.
REQ-005 SHALL have port wr_en, input, 1: MEM-stage store request.
REQ-006 SHALL have port address, input, 32: byte address (the ALU result).
REQ-007 SHALL have port write_data, input, 32: store data (the Rm value).
REQ-008 SHALL have port read_data, output, 32: load result, registered.
REQ-009 SHALL have port ready, output, 1: access complete or no access pending.
REQ-010 SHALL have port freeze, output, 1: holds every pipeline register while a memory access is in progress.
REQ-011 SHALL have port sram_addr, output, 18: SRAM half-word address.
REQ-012 SHALL have port sram_dq_out, output, 16: SRAM write data.
REQ-013 SHALL have port sram_dq_oe, output, 1: drives sram_dq_out onto the bus when high.
REQ-014 SHALL have port sram_dq_in, input, 16: SRAM read data.
REQ-015 SHALL have port sram_we_n, output, 1: SRAM write strobe, active-low.

Function
REQ-016 SHALL implement states IDLE, LOW, HIGH and DONE.
REQ-017 SHALL define req = rd_en | wr_en and is_wr = wr_en; when rd_en and wr_en are both high, the access SHALL be a write and read_data SHALL stay unchanged.
REQ-018 SHALL, in IDLE with req high, latch is_wr, address and write_data, load the phase counter with 0 and enter LOW on the next edge.
REQ-019 SHALL, in IDLE with req low, remain in IDLE.
REQ-020 SHALL stay in LOW for exactly WAIT_CYCLES cycles, then enter HIGH; SHALL stay in HIGH for exactly WAIT_CYCLES cycles, then enter DONE.
REQ-021 SHALL reset the phase counter to 0 on every phase entry.
REQ-022 SHALL stay in DONE for exactly one cycle, then return to IDLE regardless of req; a request still high in the following IDLE cycle SHALL start a new access.
REQ-023 SHALL define word offset A = latched address - 1024, 32-bit wrap-around subtraction.
REQ-024 SHALL drive sram_addr = {A[18:2], 0} in LOW, {A[18:2], 1} in HIGH, and 0 otherwise.
REQ-025 SHALL, for a write, drive sram_dq_out = data[15:0] in LOW and data[31:16] in HIGH, with sram_dq_oe = 1 and sram_we_n = 0 in both phases.
REQ-026 SHALL, for a write, drive sram_dq_out = 0 and sram_dq_oe = 0 outside LOW and HIGH; sram_we_n SHALL be 1 in all other cases.
REQ-027 SHALL, for a read, capture sram_dq_in into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-028 SHALL present read_data valid in DONE and hold it until the next read capture.
REQ-029 SHALL drive ready = 1 in DONE, ready = ~req in IDLE, and ready = 0 in LOW and HIGH.
REQ-030 SHALL drive freeze = req & ~ready, combinationally.
REQ-031 SHALL, with a request arriving at IDLE cycle 0, assert ready in cycle 2*WAIT_CYCLES+1.
REQ-032 SHALL complete a started access even if req drops mid-access; there is no abort path.
REQ-033 SHALL ignore changes on address, write_data and is_wr after IDLE latches them.

Reset
REQ-034 SHALL, while rst is high, immediately force state IDLE, phase counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1 and all latched values 0.
REQ-035 SHALL, when rst is asserted mid-access, abandon that access and leave read_data at 0; after reset is released, a pending req SHALL start a fresh access from IDLE.

Verification (WAIT_CYCLES = 2 unless stated)
REQ-036 Write 0x12345678 to address 1024 -> SRAM model holds 0x5678 at address 0 and 0x1234 at address 1; sram_we_n is low for cycles 1-4; ready is high in cycle 5 only; freeze is high in cycles 0-4.
REQ-037 Read from address 1028 with the model holding 0xBEEF at address 2 and 0xDEAD at address 3 -> read_data = 0xDEADBEEF in cycle 5; sram_dq_oe stays 0 throughout.
REQ-038 Back-to-back write then read, with req held continuously -> the second access starts in the IDLE cycle after DONE, and freeze is low only in DONE.
REQ-039 rd_en = wr_en = 1 with data 0xCAFEF00D -> a write occurs and read_data is unchanged.
REQ-040 rst pulsed in cycle 3 of a read -> state is IDLE, read_data = 0 and sram_we_n = 1 in the same cycle; after release, the held read completes 5 cycles later.
REQ-041 WAIT_CYCLES = 1, a single read -> ready is high in cycle 3.
